// File: rtl/apb_mem_pkg.sv
// Shared types and widths for the APB front-end of the 256x21 memory.
package apb_mem_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 21;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MEM  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/apb_mem_slave.sv
// APB3 slave that turns each transfer into a single-cycle strobe for a
// synchronous memory with one cycle of read latency.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = APB_ADDR_W,
    parameter int unsigned DATA_W     = APB_DATA_W,
    parameter int unsigned ADDR_LIMIT = 256,
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_ce,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (EXTRA_WAIT > 0) ? WAIT_CNT_W'(EXTRA_WAIT - 1) : '0;

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    ce_q, ce_d;
    logic                    wren_q, wren_d;
    logic                    rden_q, rden_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    addr_illegal_c;

    assign addr_illegal_c = (32'(paddr) >= 32'(ADDR_LIMIT));

    // State and capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            ce_q      <= 1'b0;
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            ce_q      <= ce_d;
            wren_q    <= wren_d;
            rden_q    <= rden_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Next state; strobes and response flags are set for the cycle being entered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        ce_d      = 1'b0;
        wren_d    = 1'b0;
        rden_d    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    if (addr_illegal_c) begin
                        state_d   = ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d = MEM;
                        ce_d    = 1'b1;
                        wren_d  = pwrite;
                        rden_d  = !pwrite;
                    end
                end
            end
            MEM: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (EXTRA_WAIT > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_ce      = ce_q;
    assign mem_wren    = wren_q;
    assign mem_rden    = rden_q;

    // Memory output is only meaningful in the response cycle of a read
    assign prdata = (state_q == RESP && !write_q) ? mem_rd_data : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three configurations, each wired to a small
// synchronous memory, checked every cycle against a timeline model.
module tb_apb_mem_slave;
    import apb_mem_pkg::*;

    localparam int NI   = 3;
    localparam int AW   = APB_ADDR_W;
    localparam int DW   = APB_DATA_W;
    localparam int NCYC = 1024;

    localparam int M_NORMAL = 0;
    localparam int M_ABORT  = 1;
    localparam int M_RESET  = 2;

    typedef struct packed {
        logic          ce;
        logic          wren;
        logic          rden;
        logic          pready;
        logic          pslverr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NI-1:0]          psel, penable, pwrite;
    logic [NI-1:0][AW-1:0]  paddr;
    logic [NI-1:0][DW-1:0]  pwdata;
    logic [NI-1:0][DW-1:0]  prdata;
    logic [NI-1:0]          pready, pslverr, mem_ce, mem_wren, mem_rden;
    logic [NI-1:0][AW-1:0]  mem_addr;
    logic [NI-1:0][DW-1:0]  mem_wr_data;

    int   cyc = 0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    exp_t          expv [NI][NCYC];
    logic [DW-1:0] mmem [NI][256];
    int            rdy_cyc  [NI];
    logic [DW-1:0] rdy_data [NI];
    logic          rdy_err  [NI];
    int            ce_cyc   [NI];
    logic [AW-1:0] ce_addr  [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ew_of(input int g);
        return (g == 1) ? 3 : 0;
    endfunction

    function automatic int al_of(input int g);
        return (g == 2) ? 128 : 256;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [DW-1:0] mem [256];
        logic [DW-1:0] rd_q;

        apb_mem_slave #(
            .ADDR_W     (AW),
            .DATA_W     (DW),
            .ADDR_LIMIT ((g == 2) ? 128 : 256),
            .EXTRA_WAIT ((g == 1) ? 3 : 0)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .psel        (psel[g]),
            .penable     (penable[g]),
            .pwrite      (pwrite[g]),
            .paddr       (paddr[g]),
            .pwdata      (pwdata[g]),
            .prdata      (prdata[g]),
            .pready      (pready[g]),
            .pslverr     (pslverr[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wr_data (mem_wr_data[g]),
            .mem_ce      (mem_ce[g]),
            .mem_wren    (mem_wren[g]),
            .mem_rden    (mem_rden[g]),
            .mem_rd_data (rd_q)
        );

        // Downstream memory: write or read at the edge closing the strobe cycle
        always_ff @(posedge clk) begin
            if (mem_ce[g] && mem_wren[g]) mem[mem_addr[g]] <= mem_wr_data[g];
            if (mem_ce[g] && mem_rden[g]) rd_q <= mem[mem_addr[g]];
        end
    end

    task automatic chk(input string what, input int g, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d actual=%0h required=%0h",
                     what, g, cyc, act, req);
        end
    endtask

    // Per-cycle comparison against the model timeline
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                e = expv[g][cyc];
                chk("pready",   g, 32'(pready[g]),   32'(e.pready));
                chk("pslverr",  g, 32'(pslverr[g]),  32'(e.pslverr));
                chk("prdata",   g, 32'(prdata[g]),   32'(e.rdata));
                chk("mem_ce",   g, 32'(mem_ce[g]),   32'(e.ce));
                chk("mem_wren", g, 32'(mem_wren[g]), 32'(e.wren));
                chk("mem_rden", g, 32'(mem_rden[g]), 32'(e.rden));
                if (e.ce)   chk("mem_addr", g, 32'(mem_addr[g]), 32'(e.addr));
                if (e.wren) chk("mem_wr_data", g, 32'(mem_wr_data[g]), 32'(e.wdata));
                if (pready[g]) begin
                    rdy_cyc[g]  = cyc;
                    rdy_data[g] = prdata[g];
                    rdy_err[g]  = pslverr[g];
                end
                if (mem_ce[g]) begin
                    ce_cyc[g]  = cyc;
                    ce_addr[g] = mem_addr[g];
                end
            end
        end
    end

    task automatic idle(input int n);
        psel    = '0;
        penable = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer; the timeline model is filled in before driving
    task automatic xfer(input int g, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int mode, input int cut,
                        output int start);
        int  n;
        int  ew;
        bit  err;
        n     = cyc;
        start = n;
        ew    = ew_of(g);
        err   = (int'(addr) >= al_of(g));
        if (n + ew + 8 >= NCYC) begin
            $display("FAIL cycle_budget inst%0d cyc%0d actual=%0d required<%0d", g, cyc, n, NCYC);
            $fatal(1);
        end
        if (err) begin
            expv[g][n+1].pready  = 1'b1;
            expv[g][n+1].pslverr = 1'b1;
        end else begin
            expv[g][n+1].ce    = 1'b1;
            expv[g][n+1].wren  = wr;
            expv[g][n+1].rden  = !wr;
            expv[g][n+1].addr  = addr;
            expv[g][n+1].wdata = data;
            if (mode == M_NORMAL) begin
                expv[g][n+2+ew].pready = 1'b1;
                if (!wr) expv[g][n+2+ew].rdata = mmem[g][addr];
            end
            if (wr) mmem[g][addr] = data;
        end

        psel[g]    = 1'b1;
        penable[g] = 1'b0;
        pwrite[g]  = wr;
        paddr[g]   = addr;
        pwdata[g]  = data;
        @(posedge clk);
        #1;
        penable[g] = 1'b1;
        if (err) begin
            @(posedge clk);
            #1;
        end else if (mode == M_ABORT) begin
            repeat (cut - 1) begin
                @(posedge clk);
                #1;
            end
            psel[g]    = 1'b0;
            penable[g] = 1'b0;
            @(posedge clk);
            #1;
        end else if (mode == M_RESET) begin
            rst_n      = 1'b0;
            psel[g]    = 1'b0;
            penable[g] = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            repeat (2 + ew) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog inst0 cyc%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        for (int g = 0; g < NI; g++) begin
            for (int c = 0; c < NCYC; c++) expv[g][c] = '0;
            for (int a = 0; a < 256; a++) mmem[g][a] = '0;
            rdy_cyc[g]  = -1;
            rdy_data[g] = '0;
            rdy_err[g]  = 1'b0;
            ce_cyc[g]   = -1;
            ce_addr[g]  = '0;
        end
        rst_n   = 1'b0;
        psel    = '0;
        penable = '0;
        pwrite  = '0;
        paddr   = '0;
        pwdata  = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_pready", 0, 32'(pready[0]), 32'h0);
        chk("rst_mem_addr", 0, 32'(mem_addr[0]), 32'h0);
        chk("rst_prdata", 1, 32'(prdata[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Basic write then read, no extra wait
        xfer(0, 1'b1, 8'h10, 21'h1ABCD, M_NORMAL, 0, s);
        chk("wr10_strobe_cyc", 0, 32'(ce_cyc[0] - s), 32'd1);
        chk("wr10_strobe_addr", 0, 32'(ce_addr[0]), 32'h10);
        idle(1);
        xfer(0, 1'b0, 8'h10, 21'h0, M_NORMAL, 0, s);
        chk("rd10_data", 0, 32'(rdy_data[0]), 32'h1ABCD);
        chk("rd10_lat", 0, 32'(rdy_cyc[0] - s), 32'd2);
        chk("rd10_err", 0, 32'(rdy_err[0]), 32'h0);
        idle(2);

        // Back-to-back write and read
        xfer(0, 1'b1, 8'h01, 21'h0AAAA, M_NORMAL, 0, s);
        xfer(0, 1'b0, 8'h01, 21'h0, M_NORMAL, 0, s);
        chk("b2b_data", 0, 32'(rdy_data[0]), 32'h0AAAA);
        chk("b2b_lat", 0, 32'(rdy_cyc[0] - s), 32'd2);

        // Access phase with no setup seen is ignored
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h01;
        pwdata[0]  = 21'h1FFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(1);

        // psel dropped in MEM of a read, then normal traffic
        xfer(0, 1'b0, 8'h20, 21'h0, M_ABORT, 1, s);
        chk("abort_no_pready", 0, 32'(rdy_cyc[0] >= s), 32'h0);
        xfer(0, 1'b1, 8'h21, 21'h00777, M_NORMAL, 0, s);
        xfer(0, 1'b0, 8'h21, 21'h0, M_NORMAL, 0, s);
        chk("post_abort_data", 0, 32'(rdy_data[0]), 32'h00777);
        xfer(0, 1'b0, 8'h01, 21'h0, M_NORMAL, 0, s);
        chk("ignored_access_data", 0, 32'(rdy_data[0]), 32'h0AAAA);
        idle(1);

        // Reset during MEM of a write: memory keeps the write
        xfer(0, 1'b1, 8'h30, 21'h12345, M_RESET, 0, s);
        chk("rstmem_ce", 0, 32'(mem_ce[0]), 32'h0);
        chk("rstmem_addr", 0, 32'(mem_addr[0]), 32'h0);
        chk("rstmem_wdata", 0, 32'(mem_wr_data[0]), 32'h0);
        idle(1);
        xfer(0, 1'b0, 8'h30, 21'h0, M_NORMAL, 0, s);
        chk("rstmem_rd_data", 0, 32'(rdy_data[0]), 32'h12345);
        idle(2);

        // Three extra wait states
        xfer(1, 1'b1, 8'hFF, 21'h00055, M_NORMAL, 0, s);
        chk("ew3_wr_lat", 1, 32'(rdy_cyc[1] - s), 32'd5);
        idle(2);
        xfer(1, 1'b0, 8'hFF, 21'h0, M_NORMAL, 0, s);
        chk("ew3_rd_lat", 1, 32'(rdy_cyc[1] - s), 32'd5);
        chk("ew3_rd_data", 1, 32'(rdy_data[1]), 32'h00055);
        chk("ew3_strobe_cyc", 1, 32'(ce_cyc[1] - s), 32'd1);
        xfer(1, 1'b0, 8'hFF, 21'h0, M_ABORT, 3, s);
        chk("ew3_abort_no_pready", 1, 32'(rdy_cyc[1] >= s), 32'h0);
        xfer(1, 1'b0, 8'hFF, 21'h0, M_NORMAL, 0, s);
        chk("ew3_post_abort_data", 1, 32'(rdy_data[1]), 32'h00055);
        idle(2);

        // Address limit 128
        xfer(2, 1'b1, 8'h7F, 21'h1FFFF, M_NORMAL, 0, s);
        xfer(2, 1'b1, 8'h80, 21'h15555, M_NORMAL, 0, s);
        chk("err_wr_lat", 2, 32'(rdy_cyc[2] - s), 32'd1);
        chk("err_wr_slverr", 2, 32'(rdy_err[2]), 32'h1);
        chk("err_wr_no_ce", 2, 32'(ce_cyc[2] > s), 32'h0);
        xfer(2, 1'b0, 8'h80, 21'h0, M_NORMAL, 0, s);
        chk("err_rd_data", 2, 32'(rdy_data[2]), 32'h0);
        chk("err_rd_slverr", 2, 32'(rdy_err[2]), 32'h1);
        xfer(2, 1'b0, 8'h7F, 21'h0, M_NORMAL, 0, s);
        chk("lim_rd_data", 2, 32'(rdy_data[2]), 32'h1FFFF);
        chk("lim_rd_slverr", 2, 32'(rdy_err[2]), 32'h0);
        idle(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
